alu_operand_stage: RTL and testbench

//  ID/EX pipeline register plus operand-forwarding front end for the EX-stage ALU.

---
 rtl/alu_operand_stage.sv | 98 +++++++++
 tb/tb_alu_operand_stage.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the EX-stage ALU.
// Also raises a combinational load-use hazard flag for the hazard unit.
module alu_operand_stage #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned PC_WIDTH      = 9,
  parameter int unsigned REG_ADDR_W    = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1,
  input  logic [REG_ADDR_W-1:0]    id_rs2,
  input  logic [REG_ADDR_W-1:0]    id_rd,
  input  logic [DATA_WIDTH-1:0]    id_rd1,
  input  logic [DATA_WIDTH-1:0]    id_rd2,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic                     id_alu_src,
  input  logic [OPCODE_LENGTH-1:0] id_operation,
  input  logic [PC_WIDTH-1:0]      id_pc,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic [REG_ADDR_W-1:0]    mem_rd,
  input  logic                     mem_reg_write,
  input  logic [DATA_WIDTH-1:0]    mem_result,
  input  logic [REG_ADDR_W-1:0]    wb_rd,
  input  logic                     wb_reg_write,
  input  logic [DATA_WIDTH-1:0]    wb_result,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [PC_WIDTH-1:0]      Pc4,
  output logic                     ex_valid,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic                     load_use
);

  logic [REG_ADDR_W-1:0]    rs1_q, rs2_q;
  logic [DATA_WIDTH-1:0]    rd1_q, rd2_q, imm_q;
  logic                     alu_src_q;
  logic [PC_WIDTH-1:0]      pc_q;
  logic [DATA_WIDTH-1:0]    fwd_a, fwd_b;

  // EX register: flush inserts an all-zero bubble, stall holds everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      ex_valid     <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      ex_rd        <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      alu_src_q    <= 1'b0;
      Operation    <= '0;
      pc_q         <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      rs1_q        <= id_rs1;
      rs2_q        <= id_rs2;
      ex_rd        <= id_rd;
      rd1_q        <= id_rd1;
      rd2_q        <= id_rd2;
      imm_q        <= id_imm;
      alu_src_q    <= id_alu_src;
      Operation    <= id_operation;
      pc_q         <= id_pc;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
    end
  end

  // Forwarding: MEM beats WB; x0 never forwards.
  always_comb begin
    fwd_a = rd1_q;
    fwd_b = rd2_q;
    if (rs1_q != '0 && mem_reg_write && mem_rd == rs1_q)     fwd_a = mem_result;
    else if (rs1_q != '0 && wb_reg_write && wb_rd == rs1_q)  fwd_a = wb_result;
    if (rs2_q != '0 && mem_reg_write && mem_rd == rs2_q)     fwd_b = mem_result;
    else if (rs2_q != '0 && wb_reg_write && wb_rd == rs2_q)  fwd_b = wb_result;
  end

  assign SrcA          = fwd_a;
  assign SrcB          = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign Pc4           = pc_q + PC_WIDTH'(4);

  assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected EX contents are queued when
// stimulus is driven and compared after the capturing edge.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [31:0] id_rd1, id_rd2, id_imm, mem_result, wb_result;
  logic        id_alu_src, id_reg_write, id_mem_read, mem_reg_write, wb_reg_write;
  logic [3:0]  id_operation;
  logic [8:0]  id_pc;
  logic [31:0] SrcA, SrcB, ex_store_data;
  logic [3:0]  Operation;
  logic [8:0]  Pc4;
  logic        ex_valid, ex_reg_write, ex_mem_read, load_use;
  logic [4:0]  ex_rd;

  int num_checks = 0;
  int num_fails  = 0;

  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic [8:0]  pc4;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
  } ex_t;

  ex_t exp_q[$];

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_alu_src(id_alu_src), .id_operation(id_operation), .id_pc(id_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .Pc4(Pc4),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_store_data(ex_store_data), .load_use(load_use)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic ex_t observe();
    ex_t o;
    o = '{v: ex_valid, op: Operation, pc4: Pc4, a: SrcA, b: SrcB, sd: ex_store_data,
          rd: ex_rd, rw: ex_reg_write, mr: ex_mem_read};
    return o;
  endfunction

  function automatic string fmt(ex_t e);
    return $sformatf("v=%0b op=%h pc4=%h a=%h b=%h sd=%h rd=%0d rw=%0b mr=%0b",
                     e.v, e.op, e.pc4, e.a, e.b, e.sd, e.rd, e.rw, e.mr);
  endfunction

  function automatic ex_t mk(logic v, logic [3:0] op, logic [8:0] pc4, logic [31:0] a,
                             logic [31:0] b, logic [31:0] sd, logic [4:0] rd,
                             logic rw, logic mr);
    ex_t e;
    e = '{v: v, op: op, pc4: pc4, a: a, b: b, sd: sd, rd: rd, rw: rw, mr: mr};
    return e;
  endfunction

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0;
    id_alu_src = 0; id_operation = 0; id_pc = 0; id_reg_write = 0; id_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  task automatic set_id(logic [4:0] rs1, logic [31:0] rd1, logic [4:0] rs2, logic [31:0] rd2,
                        logic [4:0] rd, logic [3:0] op, logic [8:0] pc, logic src,
                        logic [31:0] imm, logic rw, logic mr);
    id_valid = 1; id_rs1 = rs1; id_rd1 = rd1; id_rs2 = rs2; id_rd2 = rd2; id_rd = rd;
    id_operation = op; id_pc = pc; id_alu_src = src; id_imm = imm;
    id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic test_reset();
    ex_t o, e;
    @(negedge clk);
    set_id(5'd1, 32'h11, 5'd2, 32'h22, 5'd6, 4'd5, 9'h010, 1'b0, 32'h0, 1'b1, 1'b0);
    reset = 1;
    #1;
    e = mk(0, 0, 9'd4, 0, 0, 0, 0, 0, 0);
    o = observe();
    num_checks++;
    if (o !== e || load_use !== 1'b0) begin
      num_fails++;
      $display("FAIL reset_async: got %s lu=%0b, expected %s lu=0", fmt(o), load_use, fmt(e));
    end
    @(posedge clk); #1;
    o = observe();
    num_checks++;
    if (o !== e) begin
      num_fails++;
      $display("FAIL reset_held: got %s, expected %s", fmt(o), fmt(e));
    end
    @(negedge clk);
    reset = 0;
    exp_q.push_back(mk(1, 4'd5, 9'h014, 32'h11, 32'h22, 32'h22, 5'd6, 1, 0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    o = observe();
    num_checks++;
    if (o !== e) begin
      num_fails++;
      $display("FAIL reset_release_capture: got %s, expected %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_forward();
    ex_t o, e;
    @(negedge clk);
    idle_inputs();
    set_id(5'd3, 32'd5, 5'd7, 32'h70, 5'd8, 4'd2, 9'h020, 1'b0, 32'h0, 1'b1, 1'b0);
    mem_rd = 3; mem_reg_write = 1; mem_result = 32'd9;
    wb_rd = 3;  wb_reg_write = 1;  wb_result = 32'd7;
    exp_q.push_back(mk(1, 4'd2, 9'h024, 32'd9, 32'h70, 32'h70, 5'd8, 1, 0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    o = observe();
    num_checks++;
    if (o !== e) begin
      num_fails++;
      $display("FAIL fwd_mem_priority: got %s, expected %s", fmt(o), fmt(e));
    end
    mem_reg_write = 0; #1;
    num_checks++;
    if (SrcA !== 32'd7) begin
      num_fails++;
      $display("FAIL fwd_wb: got SrcA=%h, expected 00000007", SrcA);
    end
    wb_reg_write = 0; #1;
    num_checks++;
    if (SrcA !== 32'd5) begin
      num_fails++;
      $display("FAIL fwd_none: got SrcA=%h, expected 00000005", SrcA);
    end
    wb_rd = 7; wb_reg_write = 1; #1;
    num_checks++;
    if (SrcA !== 32'd5 || SrcB !== 32'd7 || ex_store_data !== 32'd7) begin
      num_fails++;
      $display("FAIL fwd_wb_rs2: got a=%h b=%h sd=%h, expected a=5 b=7 sd=7", SrcA, SrcB, ex_store_data);
    end
    mem_rd = 7; mem_reg_write = 1; mem_result = 32'hABCD; #1;
    num_checks++;
    if (SrcB !== 32'hABCD || ex_store_data !== 32'hABCD) begin
      num_fails++;
      $display("FAIL fwd_mem_rs2: got b=%h sd=%h, expected 0000abcd", SrcB, ex_store_data);
    end
  endtask

  task automatic test_zero_reg();
    ex_t o, e;
    @(negedge clk);
    idle_inputs();
    set_id(5'd0, 32'h44, 5'd0, 32'h33, 5'd9, 4'd1, 9'h030, 1'b0, 32'h0, 1'b1, 1'b0);
    mem_rd = 0; mem_reg_write = 1; mem_result = 32'hFF;
    wb_rd = 0;  wb_reg_write = 1;  wb_result = 32'hEE;
    exp_q.push_back(mk(1, 4'd1, 9'h034, 32'h44, 32'h33, 32'h33, 5'd9, 1, 0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    o = observe();
    num_checks++;
    if (o !== e) begin
      num_fails++;
      $display("FAIL zero_reg_no_forward: got %s, expected %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_stall_flush();
    ex_t o, e;
    @(negedge clk);
    idle_inputs();
    set_id(5'd10, 32'hA0, 5'd11, 32'hB0, 5'd12, 4'd3, 9'h040, 1'b0, 32'h0, 1'b1, 1'b1);
    exp_q.push_back(mk(1, 4'd3, 9'h044, 32'hA0, 32'hB0, 32'hB0, 5'd12, 1, 1));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    o = observe();
    num_checks++;
    if (o !== e) begin
      num_fails++;
      $display("FAIL stall_setup: got %s, expected %s", fmt(o), fmt(e));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      stall = 1;
      set_id(5'(20 + i), 32'h1234 + i, 5'd21, 32'h5678, 5'd22, 4'd9, 9'h100, 1'b1,
             32'hDEAD, 1'b0, 1'b0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      o = observe();
      num_checks++;
      if (o !== e) begin
        num_fails++;
        $display("FAIL stall_hold_%0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
    // stall must not freeze forwarding
    mem_rd = 10; mem_reg_write = 1; mem_result = 32'h5A5A; #1;
    num_checks++;
    if (SrcA !== 32'h5A5A) begin
      num_fails++;
      $display("FAIL stall_forward: got SrcA=%h, expected 00005a5a", SrcA);
    end
    @(negedge clk);
    mem_reg_write = 0;
    stall = 1; flush = 1;
    exp_q.push_back(mk(0, 0, 9'd4, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    o = observe();
    num_checks++;
    if (o !== e) begin
      num_fails++;
      $display("FAIL flush_over_stall: got %s, expected %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_load_use();
    ex_t o, e;
    @(negedge clk);
    idle_inputs();
    set_id(5'd1, 32'h1, 5'd2, 32'h2, 5'd4, 4'd0, 9'h050, 1'b0, 32'h8, 1'b1, 1'b1);
    exp_q.push_back(mk(1, 4'd0, 9'h054, 32'h1, 32'h2, 32'h2, 5'd4, 1, 1));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    o = observe();
    num_checks++;
    if (o !== e) begin
      num_fails++;
      $display("FAIL lw_capture: got %s, expected %s", fmt(o), fmt(e));
    end
    id_valid = 1; id_rs1 = 1; id_rs2 = 4; #1;
    num_checks++;
    if (load_use !== 1'b1) begin
      num_fails++;
      $display("FAIL load_use_rs2: got %0b, expected 1", load_use);
    end
    id_rs2 = 5; #1;
    num_checks++;
    if (load_use !== 1'b0) begin
      num_fails++;
      $display("FAIL load_use_nohit: got %0b, expected 0", load_use);
    end
    id_rs1 = 4; #1;
    num_checks++;
    if (load_use !== 1'b1) begin
      num_fails++;
      $display("FAIL load_use_rs1: got %0b, expected 1", load_use);
    end
    id_valid = 0; #1;
    num_checks++;
    if (load_use !== 1'b0) begin
      num_fails++;
      $display("FAIL load_use_id_invalid: got %0b, expected 0", load_use);
    end
    // lw x0 never hazards
    @(negedge clk);
    set_id(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 4'd0, 9'h060, 1'b0, 32'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    id_valid = 1; id_rs1 = 0; id_rs2 = 0; #1;
    num_checks++;
    if (load_use !== 1'b0) begin
      num_fails++;
      $display("FAIL load_use_rd0: got %0b, expected 0", load_use);
    end
    // bubble carrying a load to x4 never hazards
    set_id(5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 4'd0, 9'h070, 1'b0, 32'h0, 1'b1, 1'b1);
    id_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    id_valid = 1; id_rs1 = 4; id_rs2 = 4; #1;
    num_checks++;
    if (load_use !== 1'b0 || ex_rd !== 5'd4) begin
      num_fails++;
      $display("FAIL load_use_ex_invalid: got lu=%0b ex_rd=%0d, expected lu=0 ex_rd=4", load_use, ex_rd);
    end
  endtask

  task automatic test_pc_wrap_imm();
    ex_t o, e;
    @(negedge clk);
    idle_inputs();
    set_id(5'd6, 32'h66, 5'd2, 32'h22, 5'd7, 4'd4, 9'h1FC, 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0);
    exp_q.push_back(mk(1, 4'd4, 9'h000, 32'h66, 32'hFFFF_FFF0, 32'h22, 5'd7, 1, 0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    o = observe();
    num_checks++;
    if (o !== e) begin
      num_fails++;
      $display("FAIL pc_wrap_imm: got %s, expected %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_reset_mid_stall();
    ex_t o, e;
    @(negedge clk);
    stall = 1; reset = 1; #1;
    e = mk(0, 0, 9'd4, 0, 0, 0, 0, 0, 0);
    o = observe();
    num_checks++;
    if (o !== e) begin
      num_fails++;
      $display("FAIL reset_mid_stall: got %s, expected %s", fmt(o), fmt(e));
    end
    @(negedge clk);
    reset = 0; stall = 0;
    set_id(5'd3, 32'h33, 5'd4, 32'h44, 5'd5, 4'd6, 9'h0F0, 1'b0, 32'h0, 1'b0, 1'b0);
    exp_q.push_back(mk(1, 4'd6, 9'h0F4, 32'h33, 32'h44, 32'h44, 5'd5, 0, 0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    o = observe();
    num_checks++;
    if (o !== e) begin
      num_fails++;
      $display("FAIL capture_after_reset: got %s, expected %s", fmt(o), fmt(e));
    end
  endtask

  task automatic test_back_to_back();
    ex_t o, e;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic [3:0]  op;
    logic [8:0]  pc;
    logic        src, rw;
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));  op = 4'($urandom_range(0, 15));
      d1 = $urandom; d2 = $urandom; imm = $urandom;
      pc = 9'($urandom_range(0, 511)); src = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      set_id(rs1, d1, rs2, d2, rd, op, pc, src, imm, rw, 1'b0);
      exp_q.push_back(mk(1, op, 9'(pc + 9'd4), d1, src ? imm : d2, d2, rd, rw, 0));
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        num_checks++; num_fails++;
        $display("FAIL b2b_queue_empty_%0d: got empty scoreboard, expected one entry", i);
      end else begin
        e = exp_q.pop_front();
        o = observe();
        num_checks++;
        if (o !== e) begin
          num_fails++;
          $display("FAIL b2b_%0d: got %s, expected %s", i, fmt(o), fmt(e));
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_forward();
    test_zero_reg();
    test_stall_flush();
    test_load_use();
    test_pc_wrap_imm();
    test_reset_mid_stall();
    test_back_to_back();
    num_checks++;
    if (exp_q.size() != 0) begin
      num_fails++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
